risc_toy_fetch: RTL and testbench

- Instruction-fetch front end of the RISC_TOY pipeline. Sits between the instruction-memory port (IREQ/IADDR/INSTR) and the decode stage.
- Owns the fetch PC and issues one word request per cycle to a memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a small queue and presents them to decode through a valid/ready handshake.
- Flushes and redirects when EX resolves a taken branch or jump.

---
 rtl/risc_toy_fetch.sv | 104 ++++++++++
 tb/tb_risc_toy_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_toy_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one word request per cycle,
// and buffers {instruction, PC} pairs for decode through a small queue.
module risc_toy_fetch #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        IREQ,
    output logic [29:0] IADDR,
    input  logic [31:0] INSTR,
    output logic        ID_VALID,
    input  logic        ID_READY,
    output logic [31:0] ID_INSTR,
    output logic [29:0] ID_PC,
    input  logic        BR_TAKEN,
    input  logic [29:0] BR_TARGET
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   instr_q [DEPTH];
    logic [29:0]   pc_q    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [29:0]   pc;
    logic [29:0]   pcq_tag;
    logic          inflight;
    logic          kill;

    logic [CW:0]   occ;
    logic          has_head;
    logic          deq;
    logic          wr_en;

    // Handshake toward decode: the head transfers in any cycle where ID_VALID and
    // ID_READY are both high; ID_VALID, ID_INSTR and ID_PC stay stable while ID_READY
    // is low. A redirect masks ID_VALID so the stale head never transfers.
    assign has_head = (count != '0);
    assign ID_VALID = has_head & ~BR_TAKEN;
    assign deq      = ID_VALID & ID_READY;
    assign ID_INSTR = has_head ? instr_q[rd_ptr] : 32'h0;
    assign ID_PC    = has_head ? pc_q[rd_ptr]    : 30'h0;

    // Occupancy counts the outstanding response so the queue can never overflow;
    // a dequeue in the same cycle frees the slot the new request will need.
    assign occ   = {1'b0, count} + (CW + 1)'(inflight);
    assign IREQ  = RSTN & ~BR_TAKEN & ((occ < DEPTH_W) | ((occ == DEPTH_W) & deq));
    assign IADDR = pc;

    assign wr_en = inflight & ~kill & ~BR_TAKEN;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc       <= RESET_PC;
            pcq_tag  <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= IREQ;
            kill     <= BR_TAKEN & inflight;
            if (IREQ) begin
                pcq_tag <= pc;
            end
            if (BR_TAKEN) begin
                pc <= BR_TARGET;
            end else if (IREQ) begin
                pc <= pc + 30'd1;
            end
            if (BR_TAKEN) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (wr_en && !deq) begin
                    count <= count + CW'(1);
                end else if (!wr_en && deq) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            instr_q[wr_ptr] <= INSTR;
            pc_q[wr_ptr]    <= pcq_tag;
        end
    end

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Bench for risc_toy_fetch: 1-cycle memory returning IADDR+0x1000, a request-list
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_risc_toy_fetch;

    localparam logic [29:0] RESET_PC = 30'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        CLK       = 1'b0;
    logic        RSTN      = 1'b1;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR     = 32'h0;
    logic        ID_VALID;
    logic        ID_READY  = 1'b0;
    logic [31:0] ID_INSTR;
    logic [29:0] ID_PC;
    logic        BR_TAKEN  = 1'b0;
    logic [29:0] BR_TARGET = 30'h0;

    int n_checks = 0;
    int n_fail   = 0;

    risc_toy_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .IREQ     (IREQ),
        .IADDR    (IADDR),
        .INSTR    (INSTR),
        .ID_VALID (ID_VALID),
        .ID_READY (ID_READY),
        .ID_INSTR (ID_INSTR),
        .ID_PC    (ID_PC),
        .BR_TAKEN (BR_TAKEN),
        .BR_TARGET(BR_TARGET)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Memory: data for a request appears the following cycle; garbage otherwise.
    always @(posedge CLK) begin
        if (IREQ) INSTR <= {2'b00, IADDR} + 32'h1000;
        else      INSTR <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the list of issued-but-not-yet-delivered requests.
    // An entry issued in cycle c is visible to decode from cycle c+2.
    logic [29:0] exp_q [$];
    int          cyc_q [$];
    logic [29:0] m_pc;
    int          mcyc;

    always @(negedge CLK) begin : model
        logic        vis;
        logic        e_valid;
        logic        e_deq;
        logic        e_ireq;
        logic [29:0] e_pc;
        logic [31:0] e_instr;
        int          occ;
        if (!RSTN) begin
            check("rst_ireq",     {31'h0, IREQ},     32'h0);
            check("rst_id_valid", {31'h0, ID_VALID}, 32'h0);
            check("rst_id_instr", ID_INSTR,          32'h0);
            check("rst_id_pc",    {2'b00, ID_PC},    32'h0);
            check("rst_iaddr",    {2'b00, IADDR},    {2'b00, RESET_PC});
            exp_q.delete();
            cyc_q.delete();
            m_pc = RESET_PC;
            mcyc = 0;
        end else begin
            vis     = (exp_q.size() > 0) && (cyc_q[0] <= mcyc - 2);
            e_valid = vis && !BR_TAKEN;
            e_pc    = vis ? exp_q[0] : 30'h0;
            e_instr = vis ? ({2'b00, exp_q[0]} + 32'h1000) : 32'h0;
            e_deq   = e_valid && ID_READY;
            occ     = exp_q.size();
            e_ireq  = !BR_TAKEN && ((occ < DEPTH) || ((occ == DEPTH) && e_deq));
            check("m_ireq",     {31'h0, IREQ},     {31'h0, e_ireq});
            check("m_iaddr",    {2'b00, IADDR},    {2'b00, m_pc});
            check("m_id_valid", {31'h0, ID_VALID}, {31'h0, e_valid});
            check("m_id_pc",    {2'b00, ID_PC},    {2'b00, e_pc});
            check("m_id_instr", ID_INSTR,          e_instr);
            if (BR_TAKEN) begin
                exp_q.delete();
                cyc_q.delete();
                m_pc = BR_TARGET;
            end else begin
                if (e_deq) begin
                    void'(exp_q.pop_front());
                    void'(cyc_q.pop_front());
                end
                if (e_ireq) begin
                    exp_q.push_back(m_pc);
                    cyc_q.push_back(mcyc);
                    m_pc = m_pc + 30'd1;
                end
            end
            mcyc++;
        end
    end

    // Driver tasks: inputs change 1ns after the rising edge; checks sit on the falling edge.
    task automatic step(input logic rdy, input logic br, input logic [29:0] tgt);
        @(posedge CLK);
        #1;
        ID_READY  = rdy;
        BR_TAKEN  = br;
        BR_TARGET = tgt;
    endtask

    // One-cycle reset; returns driving cycle 0 with ID_READY=1.
    task automatic do_reset();
        @(posedge CLK);
        #1;
        RSTN     = 1'b0;
        BR_TAKEN = 1'b0;
        ID_READY = 1'b1;
        @(negedge CLK);
        check("rst_now_valid", {31'h0, ID_VALID}, 32'h0);
        check("rst_now_iaddr", {2'b00, IADDR},    {2'b00, RESET_PC});
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
    endtask

    initial begin
        // Power-on reset
        #2 RSTN = 1'b0;
        ID_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;                                    // cycle 0
        @(negedge CLK);
        check("c0_ireq",  {31'h0, IREQ},     32'h1);
        check("c0_iaddr", {2'b00, IADDR},    32'h0);
        check("c0_valid", {31'h0, ID_VALID}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 1
        @(negedge CLK);
        check("c1_iaddr", {2'b00, IADDR},    32'h1);
        check("c1_valid", {31'h0, ID_VALID}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 2
        @(negedge CLK);
        check("c2_valid", {31'h0, ID_VALID}, 32'h1);
        check("c2_pc",    {2'b00, ID_PC},    32'h0);
        check("c2_instr", ID_INSTR,          32'h1000);

        // Backpressure cycles 3..7
        step(1'b0, 1'b0, 30'h0);                           // cycle 3
        @(negedge CLK);
        check("bp_c3_ireq",  {31'h0, IREQ}, 32'h0);
        check("bp_c3_pc",    {2'b00, ID_PC}, 32'h1);
        check("bp_c3_instr", ID_INSTR,       32'h1001);
        step(1'b0, 1'b0, 30'h0);                           // cycle 4
        step(1'b0, 1'b0, 30'h0);                           // cycle 5
        @(negedge CLK);
        check("bp_c5_pc",    {2'b00, ID_PC},    32'h1);
        check("bp_c5_valid", {31'h0, ID_VALID}, 32'h1);
        check("bp_c5_ireq",  {31'h0, IREQ},     32'h0);
        step(1'b0, 1'b0, 30'h0);                           // cycle 6
        step(1'b0, 1'b0, 30'h0);                           // cycle 7
        step(1'b1, 1'b0, 30'h0);                           // cycle 8
        @(negedge CLK);
        check("bp_c8_ireq",  {31'h0, IREQ},  32'h1);
        check("bp_c8_iaddr", {2'b00, IADDR}, 32'h3);
        check("bp_c8_pc",    {2'b00, ID_PC}, 32'h1);
        step(1'b1, 1'b0, 30'h0);                           // cycle 9
        @(negedge CLK);
        check("bp_c9_pc", {2'b00, ID_PC}, 32'h2);
        step(1'b1, 1'b0, 30'h0);                           // cycle 10
        @(negedge CLK);
        check("bp_c10_pc", {2'b00, ID_PC}, 32'h3);

        // Redirect with a request in flight in cycle 6
        do_reset();                                        // cycle 0
        repeat (5) step(1'b1, 1'b0, 30'h0);                // cycles 1..5
        step(1'b1, 1'b1, 30'h40);                          // cycle 6
        @(negedge CLK);
        check("br_c6_valid", {31'h0, ID_VALID}, 32'h0);
        check("br_c6_ireq",  {31'h0, IREQ},     32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 7
        @(negedge CLK);
        check("br_c7_iaddr", {2'b00, IADDR},    32'h40);
        check("br_c7_ireq",  {31'h0, IREQ},     32'h1);
        check("br_c7_valid", {31'h0, ID_VALID}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 8
        @(negedge CLK);
        check("br_c8_valid", {31'h0, ID_VALID}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 9
        @(negedge CLK);
        check("br_c9_valid", {31'h0, ID_VALID}, 32'h1);
        check("br_c9_pc",    {2'b00, ID_PC},    32'h40);
        check("br_c9_instr", ID_INSTR,          32'h1040);

        // Redirect while the queue is full and decode is ready
        repeat (4) step(1'b0, 1'b0, 30'h0);                // cycles 10..13
        @(negedge CLK);
        check("full_c13_ireq", {31'h0, IREQ},  32'h0);
        check("full_c13_pc",   {2'b00, ID_PC}, 32'h41);
        step(1'b1, 1'b1, 30'h123);                         // cycle 14
        @(negedge CLK);
        check("full_c14_valid", {31'h0, ID_VALID}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 15
        @(negedge CLK);
        check("full_c15_iaddr", {2'b00, IADDR}, 32'h123);
        step(1'b1, 1'b0, 30'h0);                           // cycle 16
        step(1'b1, 1'b0, 30'h0);                           // cycle 17
        @(negedge CLK);
        check("full_c17_pc",    {2'b00, ID_PC}, 32'h123);
        check("full_c17_instr", ID_INSTR,       32'h1123);

        // Back-to-back redirects, second one lands near the top of the address space
        step(1'b1, 1'b0, 30'h0);                           // cycle 18
        step(1'b1, 1'b0, 30'h0);                           // cycle 19
        step(1'b1, 1'b1, 30'h200);                         // cycle 20
        step(1'b1, 1'b1, 30'h3FFF_FFFE);                   // cycle 21
        @(negedge CLK);
        check("b2b_c21_ireq", {31'h0, IREQ}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 22
        @(negedge CLK);
        check("wrap_c22_iaddr", {2'b00, IADDR}, 32'h3FFF_FFFE);
        step(1'b1, 1'b0, 30'h0);                           // cycle 23
        @(negedge CLK);
        check("wrap_c23_iaddr", {2'b00, IADDR}, 32'h3FFF_FFFF);
        step(1'b1, 1'b0, 30'h0);                           // cycle 24
        @(negedge CLK);
        check("wrap_c24_iaddr", {2'b00, IADDR}, 32'h0);
        check("wrap_c24_pc",    {2'b00, ID_PC}, 32'h3FFF_FFFE);
        check("wrap_c24_instr", ID_INSTR,       32'h4000_0FFE);
        step(1'b1, 1'b0, 30'h0);                           // cycle 25
        @(negedge CLK);
        check("wrap_c25_iaddr", {2'b00, IADDR}, 32'h1);
        check("wrap_c25_pc",    {2'b00, ID_PC}, 32'h3FFF_FFFF);
        step(1'b1, 1'b0, 30'h0);                           // cycle 26
        @(negedge CLK);
        check("wrap_c26_pc", {2'b00, ID_PC}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 27
        @(negedge CLK);
        check("wrap_c27_pc", {2'b00, ID_PC}, 32'h1);

        // Fill the queue, then reset mid-stream
        repeat (3) step(1'b0, 1'b0, 30'h0);                // cycles 28..30
        @(negedge CLK);
        check("mid_c30_valid", {31'h0, ID_VALID}, 32'h1);
        check("mid_c30_ireq",  {31'h0, IREQ},     32'h0);
        do_reset();                                        // cycle 0
        @(negedge CLK);
        check("mid_r0_iaddr", {2'b00, IADDR},    {2'b00, RESET_PC});
        check("mid_r0_ireq",  {31'h0, IREQ},     32'h1);
        check("mid_r0_valid", {31'h0, ID_VALID}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 1
        @(negedge CLK);
        check("mid_r1_valid", {31'h0, ID_VALID}, 32'h0);
        step(1'b1, 1'b0, 30'h0);                           // cycle 2
        @(negedge CLK);
        check("mid_r2_pc",    {2'b00, ID_PC}, 32'h0);
        check("mid_r2_instr", ID_INSTR,       32'h1000);

        // Mixed ready and occasional redirects, checked by the model only
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                 30'($urandom_range(0, 255)));
        end
        step(1'b1, 1'b0, 30'h0);
        repeat (4) @(posedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
